// File: rtl/fir_out_capture_if.sv
// Read-out stream of fir_out_capture: valid/ready handshake carrying signed
// samples plus an end-of-burst marker.
//   rd_valid  master->slave  rd_data/rd_last are meaningful
//   rd_ready  slave->master  consumer takes the word when rd_valid & rd_ready
//   rd_data   master->slave  signed sample
//   rd_last   master->slave  final word of the burst (only with rd_valid)
interface fir_out_capture_if #(
  parameter int DOUT_W = 16
);
  logic                     rd_valid;
  logic                     rd_ready;
  logic signed [DOUT_W-1:0] rd_data;
  logic                     rd_last;

  modport master (output rd_valid, rd_data, rd_last, input rd_ready);
  modport slave  (input rd_valid, rd_data, rd_last, output rd_ready);
endinterface

// File: rtl/fir_out_capture.sv
// On-chip logger for the fir output. After a start pulse it drops the filter's
// start-up samples, rounds/saturates every f_out to DOUT_W bits, writes a burst
// of N samples into a buffer and then streams the buffer out in capture order.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           arm a capture (only honoured in IDLE)
//   n_samples       burst length, latched on start, clamped to DEPTH
//   f_out           signed filter output, sampled every clk
//   busy            high in SKIP, CAPTURE and READ
//   done            one-cycle pulse when a burst finishes
//   sat_flag        sticky clip indicator, cleared by an accepted start
//   rd_if           read-out stream (master side)
module fir_out_capture #(
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 16,
  parameter int SHIFT  = 15,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int SKIP   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W:0]         n_samples,
  input  logic signed [DIN_W-1:0] f_out,
  output logic                    busy,
  output logic                    done,
  output logic                    sat_flag,
  fir_out_capture_if.master       rd_if
);

  localparam int YW = DIN_W - SHIFT + 1;
  localparam logic signed [DIN_W:0]  RND   = (DIN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [YW-1:0]   YMAX  = YW'((2 ** (DOUT_W - 1)) - 1);
  localparam logic signed [YW-1:0]   YMIN  = ~YMAX;
  localparam logic [ADDR_W:0]        NMAX  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]        SKIP_LAST = (SKIP > 0) ? (ADDR_W+1)'(SKIP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPT, S_READ} state_t;

  state_t state, state_nxt;

  logic [ADDR_W:0]          cnt;     // skip / capture cycle counter
  logic [ADDR_W:0]          n_lat;   // latched, clamped burst length
  logic [ADDR_W:0]          rptr;    // next buffer word to present
  logic                     y_vld;
  logic [ADDR_W-1:0]        y_addr;
  logic signed [DOUT_W-1:0] y_reg;
  logic signed [DOUT_W-1:0] mem [DEPTH];

  logic                     start_ok, last_hs, load;
  logic signed [DIN_W:0]    t;
  logic signed [YW-1:0]     y;
  logic signed [DOUT_W-1:0] y_sat;
  logic                     clip;

  assign start_ok = start && (state == S_IDLE);
  assign last_hs  = rd_if.rd_valid && rd_if.rd_ready && rd_if.rd_last;
  assign busy     = (state != S_IDLE);
  // Hold off the first fetch until the pipelined last write has landed, so a
  // read never races the write of the same address.
  assign load     = (state == S_READ) && !y_vld && (rptr != n_lat) &&
                    (!rd_if.rd_valid || rd_if.rd_ready);

  // Round half up, then clip to the DOUT_W signed range.
  always_comb begin
    t     = $signed({f_out[DIN_W-1], f_out}) + RND;
    y     = t[DIN_W:SHIFT];
    clip  = 1'b0;
    y_sat = y[DOUT_W-1:0];
    if (y > YMAX) begin
      y_sat = {1'b0, {(DOUT_W-1){1'b1}}};
      clip  = 1'b1;
    end else if (y < YMIN) begin
      y_sat = {1'b1, {(DOUT_W-1){1'b0}}};
      clip  = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && (n_samples != '0)) state_nxt = (SKIP == 0) ? S_CAPT : S_SKIP;
      S_SKIP: if (cnt == SKIP_LAST)           state_nxt = S_CAPT;
      S_CAPT: if (cnt == n_lat - 1'b1)        state_nxt = S_READ;
      S_READ: if (last_hs)                    state_nxt = S_IDLE;
      default:                                state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      n_lat          <= '0;
      rptr           <= '0;
      done           <= 1'b0;
      sat_flag       <= 1'b0;
      y_vld          <= 1'b0;
      y_addr         <= '0;
      y_reg          <= '0;
      rd_if.rd_valid <= 1'b0;
      rd_if.rd_last  <= 1'b0;
      rd_if.rd_data  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == S_IDLE || state_nxt != state) ? '0 : cnt + 1'b1;
      // n_samples==0 completes immediately; otherwise done marks the last ack.
      done  <= (start_ok && (n_samples == '0)) || last_hs;

      if (start_ok) begin
        n_lat    <= (n_samples > NMAX) ? NMAX : n_samples;
        sat_flag <= 1'b0;
        rptr     <= '0;
      end

      y_vld <= (state == S_CAPT);
      if (state == S_CAPT) begin
        y_reg  <= y_sat;
        y_addr <= cnt[ADDR_W-1:0];
        if (clip) sat_flag <= 1'b1;
      end

      if (last_hs) begin
        rd_if.rd_valid <= 1'b0;
        rd_if.rd_last  <= 1'b0;
      end else if (load) begin
        rd_if.rd_data  <= mem[rptr[ADDR_W-1:0]];
        rd_if.rd_valid <= 1'b1;
        rd_if.rd_last  <= (rptr == n_lat - 1'b1);
        rptr           <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (y_vld) mem[y_addr] <= y_reg;
  end

endmodule

// File: tb/tb_fir_out_capture.sv
module tb_fir_out_capture;
  localparam int SKIP = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [8:0]         n_samples = '0;
  logic signed [31:0] f_out = '0;
  logic               busy, done, sat_flag;

  fir_out_capture_if #(.DOUT_W(16)) rd_if ();

  fir_out_capture #(
    .DIN_W(32), .DOUT_W(16), .SHIFT(15), .DEPTH(256), .ADDR_W(8), .SKIP(SKIP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .f_out(f_out),
    .busy(busy), .done(done), .sat_flag(sat_flag), .rd_if(rd_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int q[$];
  bit lq[$];
  int stim[$];
  int done_cnt = 0;
  int rdy_mode = 0;
  bit exp_sat = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input logic signed [31:0] x, output bit c);
    longint t, y;
    t = longint'(x) + 64'sd16384;
    y = t >>> 15;
    c = 1'b0;
    if (y > 32767) begin c = 1'b1; return 32767; end
    if (y < -32768) begin c = 1'b1; return -32768; end
    return int'(y);
  endfunction

  // Consumer: drives rd_ready, checks stall stability and pops the scoreboard.
  initial begin
    bit r, stall, plast;
    int pdata, tog, e;
    bit el;
    stall = 0; tog = 0; plast = 0; pdata = 0;
    rd_if.rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 0;
      end else begin
        case (rdy_mode)
          0: r = 1'b1;
          1: begin r = (tog % 3 == 0); tog++; end
          2: r = 1'($urandom_range(0, 1));
          default: r = 1'b0;
        endcase
        rd_if.rd_ready = r;
        if (done) done_cnt++;
        if (stall) begin
          chk("stall_vld", int'(rd_if.rd_valid), 1);
          chk("stall_data", int'(rd_if.rd_data), pdata);
          chk("stall_last", int'(rd_if.rd_last), int'(plast));
        end
        if (rd_if.rd_valid && r) begin
          if (q.size() == 0) chk("extra_word", 1, 0);
          else begin
            e = q.pop_front();
            el = lq.pop_front();
            chk("data", int'(rd_if.rd_data), e);
            chk("last", int'(rd_if.rd_last), int'(el));
          end
        end
        stall = rd_if.rd_valid && !r;
        pdata = int'(rd_if.rd_data);
        plast = rd_if.rd_last;
      end
    end
  end

  // Called right after a rising edge; leaves off the same way.
  task automatic drive_burst(input int n_req, input bit mid);
    int n, idx, e;
    bit c;
    logic signed [31:0] val;
    n = (n_req > 256) ? 256 : n_req;
    start = 1'b1;
    n_samples = 9'(n_req);
    @(posedge clk); #1;
    start = 1'b0;
    exp_sat = 0;
    chk("busy_on", int'(busy), 1);
    chk("sat_clr", int'(sat_flag), 0);
    for (int k = 1; k <= SKIP + n; k++) begin
      idx = k - SKIP - 1;
      val = (idx >= 0 && idx < stim.size()) ? stim[idx] : $urandom;
      f_out = val;
      if (idx >= 0) begin
        e = model(val, c);
        exp_sat |= c;
        q.push_back(e);
        lq.push_back(idx == n - 1);
      end
      if (mid && k == SKIP + 3) begin
        start = 1'b1;
        n_samples = 9'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    f_out = $urandom;
  endtask

  task automatic wait_done(input int d0, input int bound);
    int cyc = 0;
    while (done_cnt == d0 && cyc < bound) begin
      @(posedge clk);
      cyc++;
    end
    chk("done_seen", int'(done_cnt != d0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("q_drained", q.size(), 0);
    chk("busy_off", int'(busy), 0);
    chk("sat", int'(sat_flag), int'(exp_sat));
  endtask

  initial begin
    int d0, cyc;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sat", int'(sat_flag), 0);
    chk("rst_valid", int'(rd_if.rd_valid), 0);
    chk("rst_data", int'(rd_if.rd_data), 0);
    #13 rst = 1'b1;
    @(posedge clk); #1;

    // rounding
    stim = '{16384, -49152, 32767, -16385};
    rdy_mode = 0; d0 = done_cnt;
    drive_burst(4, 0); wait_done(d0, 200);

    // saturation; the following start must clear the sticky flag
    stim = '{32'h7FFF_FFFF, 32'h8000_0000};
    d0 = done_cnt;
    drive_burst(2, 0); wait_done(d0, 200);
    chk("sat_set", int'(sat_flag), 1);

    // backpressure ramp
    stim.delete();
    for (int k = 0; k < 8; k++) stim.push_back(k << 15);
    rdy_mode = 1; d0 = done_cnt;
    drive_burst(8, 0); wait_done(d0, 300);

    // clamp to depth
    stim.delete();
    rdy_mode = 2; d0 = done_cnt;
    drive_burst(300, 0); wait_done(d0, 2000);

    // zero-length burst
    d0 = done_cnt;
    start = 1'b1; n_samples = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("n0_done", int'(done), 1);
    chk("n0_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("n0_done_off", int'(done), 0);
    chk("n0_busy2", int'(busy), 0);
    chk("n0_cnt", done_cnt - d0, 1);

    // start during capture is ignored
    rdy_mode = 0; d0 = done_cnt;
    drive_burst(10, 1); wait_done(d0, 300);

    // reset during read-out aborts without done
    stim.delete();
    for (int k = 0; k < 8; k++) stim.push_back((k + 3) << 15);
    rdy_mode = 3; d0 = done_cnt;
    drive_burst(8, 0);
    cyc = 0;
    while (!rd_if.rd_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("rv_rise", int'(rd_if.rd_valid), 1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_valid", int'(rd_if.rd_valid), 0);
    chk("ar_last", int'(rd_if.rd_last), 0);
    chk("ar_data", int'(rd_if.rd_data), 0);
    q.delete(); lq.delete();
    @(negedge clk) rst = 1'b1;
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    chk("ar_no_done", done_cnt - d0, 0);

    // normal operation after reset
    stim.delete();
    d0 = done_cnt;
    drive_burst(20, 0); wait_done(d0, 300);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
    $fatal(1, "watchdog");
  end
endmodule
